// File: rtl/shift_pipe_if.sv
// shift_pipe_if: request/result handshake bundle for shift_pipe.
//   slave  : the shifter's view (accepts requests, produces results)
//   master : the issuing/consuming side's view
//   in_*   : operand, distance, op (00 SLL, 01 SRL, 10 SRA, 11 ROR), tag
//   out_*  : result data and the tag that travelled with it
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DISTW = 5,
  parameter int TAGW  = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DISTW-1:0] in_dist;
  logic [1:0]       in_op;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAGW-1:0]  out_tag;

  modport slave (
    input  in_valid, in_data, in_dist, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_dist, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready
// handshake and a tag carried alongside each operation.
//   clock, rst_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_data/in_dist/in_op/in_tag request,
//                  out_valid/out_ready/out_data/out_tag result
// Shifter level k (shift by 2^k) lives in stage floor(k*STAGES/DISTW).
// Each stage holds valid, partial data, op, dist, tag and the operand's
// original sign bit, which SRA uses as fill in the later levels.

// One pipeline stage: applies its share of the shifter levels to the
// upstream payload and registers the result when allowed to load.
module shift_pipe_stage #(
  parameter int WIDTH  = 32,
  parameter int DISTW  = 5,
  parameter int TAGW   = 4,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic [DISTW-1:0] dist_i,
  input  logic [TAGW-1:0]  tag_i,
  input  logic             sign_i,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q,
  output logic [1:0]       op_q,
  output logic [DISTW-1:0] dist_q,
  output logic [TAGW-1:0]  tag_q,
  output logic             sign_q
);
  logic             vld_d;
  logic [WIDTH-1:0] data_d;
  logic [1:0]       op_d;
  logic [DISTW-1:0] dist_d;
  logic [TAGW-1:0]  tag_d;
  logic             sign_d;
  logic [WIDTH-1:0] shifted;
  logic             take;

  // Single level: shift by the constant s for the given op.
  function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] op,
                                                 input logic sgn,
                                                 input int s);
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
    case (op)
      2'b00:   shift_lvl = d << s;
      2'b01:   shift_lvl = d >> s;
      2'b10:   shift_lvl = (d >> s) | fill;
      default: shift_lvl = (d >> s) | (d << (WIDTH - s));
    endcase
  endfunction

  always_comb begin
    shifted = data_i;
    for (int k = 0; k < DISTW; k++)
      if (((k * STAGES) / DISTW) == IDX && dist_i[k])
        shifted = shift_lvl(shifted, op_i, sign_i, 1 << k);

    // Payload only moves with a real operation, so a bubble passing
    // through never disturbs the registered data.
    take   = ld && vld_i;
    vld_d  = ld ? vld_i : vld_q;
    data_d = take ? shifted : data_q;
    op_d   = take ? op_i    : op_q;
    dist_d = take ? dist_i  : dist_q;
    tag_d  = take ? tag_i   : tag_q;
    sign_d = take ? sign_i  : sign_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      op_q   <= '0;
      dist_q <= '0;
      tag_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      op_q   <= op_d;
      dist_q <= dist_d;
      tag_q  <= tag_d;
      sign_q <= sign_d;
    end
  end
endmodule

module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int DISTW  = 5,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  shift_pipe_if.slave bus
);
  // Index 0 is the request port; index i+1 is the output of stage i.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] data_p;
  logic [STAGES:0][1:0]       op_p;
  logic [STAGES:0][DISTW-1:0] dist_p;
  logic [STAGES:0][TAGW-1:0]  tag_p;
  logic [STAGES:0]            sign_p;
  // ld[i]: stage i loads this cycle; ld[STAGES] is the consumer taking data.
  logic [STAGES:0]            ld;
  logic                       unused_tail;

  assign vld_pipe[0] = bus.in_valid;
  assign data_p[0]   = bus.in_data;
  assign op_p[0]     = bus.in_op;
  assign dist_p[0]   = bus.in_dist;
  assign tag_p[0]    = bus.in_tag;
  assign sign_p[0]   = bus.in_data[WIDTH-1];

  assign ld[STAGES]  = bus.out_ready;

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      // An empty stage always loads, so bubbles collapse toward the output.
      assign ld[i] = !vld_pipe[i+1] || ld[i+1];

      shift_pipe_stage #(
        .WIDTH(WIDTH), .DISTW(DISTW), .TAGW(TAGW), .STAGES(STAGES), .IDX(i)
      ) u_stage (
        .clock  (clock),
        .rst_n  (rst_n),
        .ld     (ld[i]),
        .vld_i  (vld_pipe[i]),
        .data_i (data_p[i]),
        .op_i   (op_p[i]),
        .dist_i (dist_p[i]),
        .tag_i  (tag_p[i]),
        .sign_i (sign_p[i]),
        .vld_q  (vld_pipe[i+1]),
        .data_q (data_p[i+1]),
        .op_q   (op_p[i+1]),
        .dist_q (dist_p[i+1]),
        .tag_q  (tag_p[i+1]),
        .sign_q (sign_p[i+1])
      );
    end
  endgenerate

  // in_ready depends only on out_ready and stage occupancy, never in_valid.
  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = data_p[STAGES];
  assign bus.out_tag   = tag_p[STAGES];

  // The final stage's control fields have no further consumer.
  assign unused_tail = ^{op_p[STAGES], dist_p[STAGES], sign_p[STAGES]};
endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;
  localparam int W = 32;
  localparam int D = 5;
  localparam int T = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  shift_pipe_if #(.WIDTH(W), .DISTW(D), .TAGW(T)) b2 ();
  shift_pipe_if #(.WIDTH(W), .DISTW(D), .TAGW(T)) b1 ();
  shift_pipe_if #(.WIDTH(W), .DISTW(D), .TAGW(T)) b3 ();
  shift_pipe_if #(.WIDTH(W), .DISTW(D), .TAGW(T)) b5 ();

  shift_pipe #(.WIDTH(W), .DISTW(D), .STAGES(2), .TAGW(T)) u_dut (.clock(clock), .rst_n(rst_n), .bus(b2));
  shift_pipe #(.WIDTH(W), .DISTW(D), .STAGES(1), .TAGW(T)) u_s1  (.clock(clock), .rst_n(rst_n), .bus(b1));
  shift_pipe #(.WIDTH(W), .DISTW(D), .STAGES(3), .TAGW(T)) u_s3  (.clock(clock), .rst_n(rst_n), .bus(b3));
  shift_pipe #(.WIDTH(W), .DISTW(D), .STAGES(5), .TAGW(T)) u_s5  (.clock(clock), .rst_n(rst_n), .bus(b5));

  // Shared random stimulus for the STAGES 1/3/5 instances.
  logic          r_valid, r_oready;
  logic [W-1:0]  r_data;
  logic [D-1:0]  r_dist;
  logic [1:0]    r_op;
  logic [T-1:0]  r_tag;

  assign b1.in_valid = r_valid; assign b1.in_data = r_data; assign b1.in_dist = r_dist;
  assign b1.in_op = r_op; assign b1.in_tag = r_tag; assign b1.out_ready = r_oready;
  assign b3.in_valid = r_valid; assign b3.in_data = r_data; assign b3.in_dist = r_dist;
  assign b3.in_op = r_op; assign b3.in_tag = r_tag; assign b3.out_ready = r_oready;
  assign b5.in_valid = r_valid; assign b5.in_data = r_data; assign b5.in_dist = r_dist;
  assign b5.in_op = r_op; assign b5.in_tag = r_tag; assign b5.out_ready = r_oready;

  logic         rdy  [3];
  logic         ovld [3];
  logic [W-1:0] odat [3];
  logic [T-1:0] otag [3];
  assign rdy[0] = b1.in_ready; assign ovld[0] = b1.out_valid; assign odat[0] = b1.out_data; assign otag[0] = b1.out_tag;
  assign rdy[1] = b3.in_ready; assign ovld[1] = b3.out_valid; assign odat[1] = b3.out_data; assign otag[1] = b3.out_tag;
  assign rdy[2] = b5.in_ready; assign ovld[2] = b5.out_valid; assign odat[2] = b5.out_data; assign otag[2] = b5.out_tag;

  // Expected-result FIFOs per random instance: {tag, data}.
  logic [T+W-1:0] ring [3][16];
  int hd [3];
  int tl [3];

  logic [31:0] exp4 [4] = '{32'h87654320, 32'h09876543, 32'hF9876543, 32'h29876543};
  logic [31:0] bd [6];
  logic [4:0]  bn [6];
  logic [1:0]  bo [6];
  logic [31:0] res;
  int acc, got;

  // Reference: shift semantics in plain arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input logic [1:0] op);
    logic [63:0] dd;
    case (op)
      2'b00:   ref_shift = d << n;
      2'b01:   ref_shift = d >> n;
      2'b10:   ref_shift = 32'($signed(d) >>> n);
      default: begin dd = {d, d} >> n; ref_shift = dd[31:0]; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] n, input logic [1:0] op, input logic [3:0] tg);
    b2.in_data = d; b2.in_dist = n; b2.in_op = op; b2.in_tag = tg;
  endtask

  task automatic run_one(input logic [31:0] d, input logic [4:0] n, input logic [1:0] op, output logic [31:0] r);
    int cnt;
    b2.out_ready = 1'b1;
    b2.in_valid  = 1'b1;
    drive(d, n, op, 4'hA);
    step();
    b2.in_valid = 1'b0;
    cnt = 0;
    while (!b2.out_valid && cnt < 10) begin step(); cnt++; end
    chk("one_timeout", 64'(b2.out_valid), 64'(1));
    chk("one_tag", 64'(b2.out_tag), 64'(4'hA));
    r = b2.out_data;
    step();
  endtask

  task automatic rnd_cycle(input logic gen);
    if (gen) begin
      r_valid  = ($urandom_range(3) != 0);
      r_oready = ($urandom_range(3) != 0);
      r_data   = $urandom;
      r_dist   = 5'($urandom);
      r_op     = 2'($urandom);
      r_tag    = 4'($urandom);
    end else begin
      r_valid  = 1'b0;
      r_oready = 1'b1;
    end
    #1;
    for (int j = 0; j < 3; j++) begin
      if (ovld[j] && r_oready) begin
        if (hd[j] == tl[j]) chk("rnd_spurious", 64'(1), 64'(0));
        else begin
          chk("rnd_data", 64'(odat[j]), 64'(ring[j][hd[j] % 16][W-1:0]));
          chk("rnd_tag",  64'(otag[j]), 64'(ring[j][hd[j] % 16][T+W-1:W]));
          hd[j]++;
        end
      end
      if (r_valid && rdy[j]) begin
        ring[j][tl[j] % 16] = {r_tag, ref_shift(r_data, int'(r_dist), r_op)};
        tl[j]++;
      end
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    drive(32'h0, 5'd0, 2'b00, 4'h0);
    r_valid = 1'b0; r_oready = 1'b0; r_data = '0; r_dist = '0; r_op = '0; r_tag = '0;
    for (int j = 0; j < 3; j++) begin hd[j] = 0; tl[j] = 0; end

    // Reset state
    #12;
    chk("rst_out_valid", 64'(b2.out_valid), 64'(0));
    chk("rst_out_data",  64'(b2.out_data),  64'(0));
    chk("rst_out_tag",   64'(b2.out_tag),   64'(0));
    chk("rst_s5_valid",  64'(b5.out_valid), 64'(0));
    @(posedge clock); #1;
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(b2.in_ready), 64'(1));

    // Back-to-back four ops, latency 2, tags preserved
    b2.out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      b2.in_valid = (t < 4);
      drive(32'h98765432, 5'd4, 2'(t), 4'(t + 1));
      #1;
      if (t < 4) chk("b2b_in_ready", 64'(b2.in_ready), 64'(1));
      chk("b2b_out_valid", 64'(b2.out_valid), 64'(t >= 2 && t < 6));
      if (t >= 2 && t < 6) begin
        chk("b2b_data", 64'(b2.out_data), 64'(exp4[t-2]));
        chk("b2b_tag",  64'(b2.out_tag),  64'(t - 1));
      end
      step();
    end

    // Boundary distances
    run_one(32'h98765432, 5'd31, 2'b10, res); chk("sra31_neg", 64'(res), 64'(32'hFFFFFFFF));
    run_one(32'h08765432, 5'd31, 2'b10, res); chk("sra31_pos", 64'(res), 64'(32'h00000000));
    run_one(32'h98765432, 5'd8,  2'b11, res); chk("ror8",      64'(res), 64'(32'h32987654));
    for (int op = 0; op < 4; op++) begin
      run_one(32'h98765432, 5'd0, 2'(op), res);
      chk("dist0", 64'(res), 64'(32'h98765432));
    end

    // Backpressure: only two fit
    for (int k = 0; k < 6; k++) begin
      bd[k] = $urandom; bn[k] = 5'($urandom); bo[k] = 2'($urandom);
    end
    b2.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      b2.in_valid = 1'b1;
      drive(bd[acc], bn[acc], bo[acc], 4'(acc));
      #1;
      if (b2.in_ready) acc++;
      step();
    end
    chk("bp_accepted", 64'(acc), 64'(2));
    chk("bp_in_ready", 64'(b2.in_ready), 64'(0));
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 64'(b2.out_valid), 64'(1));
      chk("bp_hold_data",  64'(b2.out_data),  64'(ref_shift(bd[0], int'(bn[0]), bo[0])));
      chk("bp_hold_tag",   64'(b2.out_tag),   64'(0));
    end
    b2.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      b2.in_valid = (acc < 6);
      if (acc < 6) drive(bd[acc], bn[acc], bo[acc], 4'(acc));
      #1;
      chk("drain_in_ready", 64'(b2.in_ready), 64'(1));
      if (b2.out_valid) begin
        chk("drain_data", 64'(b2.out_data), 64'(ref_shift(bd[got], int'(bn[got]), bo[got])));
        chk("drain_tag",  64'(b2.out_tag),  64'(got));
        got++;
      end
      if (b2.in_valid && b2.in_ready) acc++;
      step();
    end
    b2.in_valid = 1'b0;
    chk("drain_count", 64'(got), 64'(6));
    chk("drain_empty", 64'(b2.out_valid), 64'(0));

    // Bubble collapse
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1;
    drive(32'h11111111, 5'd1, 2'b00, 4'h5);
    #1;
    chk("bub_first_ready", 64'(b2.in_ready), 64'(1));
    step();
    b2.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    b2.in_valid = 1'b1;
    drive(32'h80000001, 5'd3, 2'b10, 4'h6);
    #1;
    chk("bub_second_ready", 64'(b2.in_ready), 64'(1));
    step();
    b2.in_valid = 1'b0;
    #1;
    chk("bub_full", 64'(b2.in_ready), 64'(0));
    b2.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 8 && got < 2; c++) begin
      #1;
      if (b2.out_valid) begin
        chk("bub_data", 64'(b2.out_data), 64'(got == 0 ? 32'h22222222 : 32'hF0000000));
        chk("bub_tag",  64'(b2.out_tag),  64'(got == 0 ? 4'h5 : 4'h6));
        got++;
      end
      step();
    end
    chk("bub_count", 64'(got), 64'(2));

    // Reset with two in flight
    b2.in_valid = 1'b1;
    drive(32'hCAFEF00D, 5'd7, 2'b01, 4'h9);
    step();
    drive(32'h12345678, 5'd2, 2'b00, 4'hB);
    step();
    b2.in_valid = 1'b0;
    #2;
    chk("rst_pre_valid", 64'(b2.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(b2.out_valid), 64'(0));
    chk("rst_async_data",  64'(b2.out_data),  64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_rel_ready", 64'(b2.in_ready), 64'(1));
    for (int c = 0; c < 6; c++) begin
      chk("rst_no_emit", 64'(b2.out_valid), 64'(0));
      step();
    end

    // Random traffic on STAGES 1, 3, 5
    for (int c = 0; c < 10000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 12; c++) rnd_cycle(1'b0);
    for (int j = 0; j < 3; j++) chk("rnd_leftover", 64'(tl[j] - hd[j]), 64'(0));
    chk("rnd_activity", 64'(tl[0] > 1000 && tl[2] > 1000), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
